// File: rtl/ace_ccu_snoop_fanout.sv
// rtl/ace_ccu_snoop_fanout.sv - ACE snoop broadcaster with CR merge and single-source CD forwarding
//
// Purpose: accepts one AC snoop plus a target mask, broadcasts it to the selected
// cache snoop ports, merges their CR responses into one CR, then forwards a single
// CD line from the lowest-index data-transferring cache and drains all other CD.
//
// Ports:
//   clk_i, rst_i                         clock, synchronous active-high reset
//   inp_ac_*  / inp_sel_i                upstream AC request and target mask
//   inp_cr_*                             merged CR response to upstream
//   inp_cd_*                             forwarded CD line to upstream
//   oup_ac_*                             per-port AC valid/ready, shared AC payload
//   oup_cr_*                             per-port CR handshake and response (5 bits per port)
//   oup_cd_*                             per-port CD handshake, data and last
module ace_ccu_snoop_fanout #(
    parameter int NoPorts         = 4,
    parameter int AddrWidth       = 64,
    parameter int DataWidth       = 64,
    parameter int DcacheLineWidth = 128
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           inp_ac_valid_i,
    output logic                           inp_ac_ready_o,
    input  logic [AddrWidth-1:0]           inp_ac_addr_i,
    input  logic [3:0]                     inp_ac_snoop_i,
    input  logic [2:0]                     inp_ac_prot_i,
    input  logic [NoPorts-1:0]             inp_sel_i,
    output logic                           inp_cr_valid_o,
    input  logic                           inp_cr_ready_i,
    output logic [4:0]                     inp_cr_resp_o,
    output logic                           inp_cd_valid_o,
    input  logic                           inp_cd_ready_i,
    output logic [DataWidth-1:0]           inp_cd_data_o,
    output logic                           inp_cd_last_o,
    output logic [NoPorts-1:0]             oup_ac_valid_o,
    input  logic [NoPorts-1:0]             oup_ac_ready_i,
    output logic [AddrWidth-1:0]           oup_ac_addr_o,
    output logic [3:0]                     oup_ac_snoop_o,
    output logic [2:0]                     oup_ac_prot_o,
    input  logic [NoPorts-1:0]             oup_cr_valid_i,
    output logic [NoPorts-1:0]             oup_cr_ready_o,
    input  logic [5*NoPorts-1:0]           oup_cr_resp_i,
    input  logic [NoPorts-1:0]             oup_cd_valid_i,
    output logic [NoPorts-1:0]             oup_cd_ready_o,
    input  logic [DataWidth*NoPorts-1:0]   oup_cd_data_i,
    input  logic [NoPorts-1:0]             oup_cd_last_i
);

    localparam int CdBeats = DcacheLineWidth / DataWidth;
    localparam int CntW    = (CdBeats > 1) ? $clog2(CdBeats) : 1;
    localparam int SrcW    = (NoPorts > 1) ? $clog2(NoPorts) : 1;
    localparam logic [CntW-1:0] LastBeat = CntW'(CdBeats - 1);

    typedef enum logic [1:0] {IDLE, SNOOP, RESP, DATA} state_t;

    state_t             state;
    logic [NoPorts-1:0] sel_q;
    logic [NoPorts-1:0] ac_pend;
    logic [NoPorts-1:0] cr_pend;
    logic [NoPorts-1:0] cd_pend;
    logic [NoPorts-1:0] pd_mask;    // PassDirty reported per port, resolved once src is known
    logic [4:0]         resp;
    logic [SrcW-1:0]    src;
    logic [CntW-1:0]    beat_cnt [NoPorts];

    logic [NoPorts-1:0] ac_hs, cr_hs, cd_hs, cr_dt, cr_pd, cd_done;
    logic [NoPorts-1:0] cd_pend_nxt, pd_mask_nxt;
    logic [4:0]         cr_or;
    logic [SrcW-1:0]    src_nxt;

    assign inp_ac_ready_o = (state == IDLE) && !rst_i;
    assign inp_cr_valid_o = (state == RESP);
    assign inp_cr_resp_o  = resp;

    always_comb begin
        oup_ac_valid_o = (state == SNOOP) ? ac_pend : '0;
        // A port's CR is only taken once its AC has been handed over.
        oup_cr_ready_o = (state == SNOOP) ? (cr_pend & ~ac_pend) : '0;
        oup_cd_ready_o = '0;
        inp_cd_valid_o = 1'b0;
        inp_cd_data_o  = '0;
        inp_cd_last_o  = 1'b0;
        if (state == DATA) begin
            for (int i = 0; i < NoPorts; i++) begin
                if (cd_pend[i]) begin
                    oup_cd_ready_o[i] = (SrcW'(i) == src) ? inp_cd_ready_i : 1'b1;
                end
            end
            if (cd_pend[src]) begin
                inp_cd_valid_o = oup_cd_valid_i[src];
                inp_cd_data_o  = oup_cd_data_i[src*DataWidth +: DataWidth];
                inp_cd_last_o  = (beat_cnt[src] == LastBeat);
            end
        end

        ac_hs   = oup_ac_valid_o & oup_ac_ready_i;
        cr_hs   = oup_cr_ready_o & oup_cr_valid_i;
        cd_hs   = oup_cd_ready_o & oup_cd_valid_i;
        cr_or   = '0;
        cr_dt   = '0;
        cr_pd   = '0;
        cd_done = '0;
        for (int i = 0; i < NoPorts; i++) begin
            if (cr_hs[i]) begin
                cr_or    = cr_or | oup_cr_resp_i[5*i +: 5];
                cr_dt[i] = oup_cr_resp_i[5*i];
                cr_pd[i] = oup_cr_resp_i[5*i + 2];
            end
            if (cd_hs[i] && (beat_cnt[i] == LastBeat)) begin
                cd_done[i] = 1'b1;
            end
        end
        cd_pend_nxt = cd_pend | cr_dt;
        pd_mask_nxt = pd_mask | cr_pd;
        // Data source is the lowest-index port that reported DataTransfer.
        src_nxt = '0;
        for (int i = NoPorts - 1; i >= 0; i--) begin
            if (cd_pend_nxt[i]) begin
                src_nxt = SrcW'(i);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            sel_q          <= '0;
            ac_pend        <= '0;
            cr_pend        <= '0;
            cd_pend        <= '0;
            pd_mask        <= '0;
            resp           <= '0;
            src            <= '0;
            oup_ac_addr_o  <= '0;
            oup_ac_snoop_o <= '0;
            oup_ac_prot_o  <= '0;
            for (int i = 0; i < NoPorts; i++) begin
                beat_cnt[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (inp_ac_valid_i) begin
                        oup_ac_addr_o  <= inp_ac_addr_i;
                        oup_ac_snoop_o <= inp_ac_snoop_i;
                        oup_ac_prot_o  <= inp_ac_prot_i;
                        sel_q          <= inp_sel_i;
                        ac_pend        <= inp_sel_i;
                        cr_pend        <= inp_sel_i;
                        cd_pend        <= '0;
                        pd_mask        <= '0;
                        resp           <= '0;
                        state          <= (inp_sel_i != '0) ? SNOOP : RESP;
                    end
                end
                SNOOP: begin
                    ac_pend <= ac_pend & ~ac_hs;
                    cr_pend <= cr_pend & ~cr_hs;
                    cd_pend <= cd_pend_nxt;
                    pd_mask <= pd_mask_nxt;
                    resp    <= resp | {cr_or[4:3], 1'b0, cr_or[1:0]};
                    if (((ac_pend & ~ac_hs) == '0) && ((cr_pend & ~cr_hs) == '0)) begin
                        state   <= RESP;
                        src     <= src_nxt;
                        resp[2] <= pd_mask_nxt[src_nxt];
                    end
                end
                RESP: begin
                    if (inp_cr_ready_i) begin
                        state <= resp[0] ? DATA : IDLE;
                    end
                end
                DATA: begin
                    for (int i = 0; i < NoPorts; i++) begin
                        if (cd_hs[i]) begin
                            beat_cnt[i] <= cd_done[i] ? '0 : beat_cnt[i] + CntW'(1);
                        end
                    end
                    cd_pend <= cd_pend & ~cd_done;
                    if ((cd_pend & ~cd_done) == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NoPorts; i++) begin
                if (cd_hs[i]) begin
                    assert (oup_cd_last_i[i] == (beat_cnt[i] == LastBeat))
                        else $error("cd last misaligned on port %0d", i);
                end
            end
            if (state != IDLE) begin
                assert ((oup_cr_valid_i & ~sel_q) == '0)
                    else $error("cr valid on unselected port");
            end
        end
    end

endmodule

// File: tb/tb_ace_ccu_snoop_fanout.sv
// tb/tb_ace_ccu_snoop_fanout.sv - directed table-driven bench for ace_ccu_snoop_fanout
module tb_ace_ccu_snoop_fanout;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         inp_ac_valid_i;
    logic         inp_ac_ready_o;
    logic [63:0]  inp_ac_addr_i;
    logic [3:0]   inp_ac_snoop_i;
    logic [2:0]   inp_ac_prot_i;
    logic [3:0]   inp_sel_i;
    logic         inp_cr_valid_o;
    logic         inp_cr_ready_i;
    logic [4:0]   inp_cr_resp_o;
    logic         inp_cd_valid_o;
    logic         inp_cd_ready_i;
    logic [63:0]  inp_cd_data_o;
    logic         inp_cd_last_o;
    logic [3:0]   oup_ac_valid_o;
    logic [3:0]   oup_ac_ready_i;
    logic [63:0]  oup_ac_addr_o;
    logic [3:0]   oup_ac_snoop_o;
    logic [2:0]   oup_ac_prot_o;
    logic [3:0]   oup_cr_valid_i;
    logic [3:0]   oup_cr_ready_o;
    logic [19:0]  oup_cr_resp_i;
    logic [3:0]   oup_cd_valid_i;
    logic [3:0]   oup_cd_ready_o;
    logic [255:0] oup_cd_data_i;
    logic [3:0]   oup_cd_last_i;

    int n_tests = 0;
    int n_fail  = 0;

    ace_ccu_snoop_fanout dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inp_ac_valid_i (inp_ac_valid_i),
        .inp_ac_ready_o (inp_ac_ready_o),
        .inp_ac_addr_i  (inp_ac_addr_i),
        .inp_ac_snoop_i (inp_ac_snoop_i),
        .inp_ac_prot_i  (inp_ac_prot_i),
        .inp_sel_i      (inp_sel_i),
        .inp_cr_valid_o (inp_cr_valid_o),
        .inp_cr_ready_i (inp_cr_ready_i),
        .inp_cr_resp_o  (inp_cr_resp_o),
        .inp_cd_valid_o (inp_cd_valid_o),
        .inp_cd_ready_i (inp_cd_ready_i),
        .inp_cd_data_o  (inp_cd_data_o),
        .inp_cd_last_o  (inp_cd_last_o),
        .oup_ac_valid_o (oup_ac_valid_o),
        .oup_ac_ready_i (oup_ac_ready_i),
        .oup_ac_addr_o  (oup_ac_addr_o),
        .oup_ac_snoop_o (oup_ac_snoop_o),
        .oup_ac_prot_o  (oup_ac_prot_o),
        .oup_cr_valid_i (oup_cr_valid_i),
        .oup_cr_ready_o (oup_cr_ready_o),
        .oup_cr_resp_i  (oup_cr_resp_i),
        .oup_cd_valid_i (oup_cd_valid_i),
        .oup_cd_ready_o (oup_cd_ready_o),
        .oup_cd_data_i  (oup_cd_data_i),
        .oup_cd_last_i  (oup_cd_last_i)
    );

    always #5 clk_i = ~clk_i;

    wire [155:0] all_out = {inp_ac_ready_o, inp_cr_valid_o, inp_cr_resp_o, inp_cd_valid_o,
                            inp_cd_data_o, inp_cd_last_o, oup_ac_valid_o, oup_ac_addr_o,
                            oup_ac_snoop_o, oup_ac_prot_o, oup_cr_ready_o, oup_cd_ready_o};

    typedef struct packed {
        logic [3:0]      sel;
        logic [19:0]     cr;          // port i response at [5i+4:5i]
        logic [3:0][7:0] ac_rdy;      // cycle from which port raises AC ready
        logic [3:0][7:0] cr_cyc;      // cycle from which port presents CR
        int              cr_rdy_dly;  // upstream CR ready after this many valid cycles
        logic            cd_toggle;   // upstream CD ready alternates when set
        logic [4:0]      exp_resp;
        int              exp_crv;     // cycle of first merged CR valid
        int              exp_src;
        int              exp_beats;   // forwarded beats
        int              exp_drain;   // total downstream CD handshakes
    } vec_t;

    vec_t vecs [6];

    function automatic vec_t mk(input logic [3:0] sel, input logic [19:0] cr,
                                input logic [3:0][7:0] ac_rdy, input logic [3:0][7:0] cr_cyc,
                                input int dly, input logic tog, input logic [4:0] er,
                                input int ecrv, input int esrc, input int ebeats, input int edrain);
        vec_t v;
        v.sel = sel; v.cr = cr; v.ac_rdy = ac_rdy; v.cr_cyc = cr_cyc;
        v.cr_rdy_dly = dly; v.cd_toggle = tog; v.exp_resp = er; v.exp_crv = ecrv;
        v.exp_src = esrc; v.exp_beats = ebeats; v.exp_drain = edrain;
        return v;
    endfunction

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        inp_ac_valid_i = 1'b0; inp_ac_addr_i = '0; inp_ac_snoop_i = '0; inp_ac_prot_i = '0;
        inp_sel_i = '0; inp_cr_ready_i = 1'b0; inp_cd_ready_i = 1'b0;
        oup_ac_ready_i = '0; oup_cr_valid_i = '0; oup_cr_resp_i = '0;
        oup_cd_valid_i = '0; oup_cd_data_i = '0; oup_cd_last_i = '0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [3:0]  ac_done, cr_done, dt, prev_acv, prev_ac_hs;
        int          cd_cnt [4];
        int          cyc, crv_cyc, crv_seen, fwd_cnt, viol, drain;
        logic [4:0]  got_resp;
        logic        cr_taken, done, prev_cdv, prev_last;
        logic [63:0] prev_data, addr, exp_data;
        logic [3:0]  snp;
        ac_done = '0; cr_done = '0; prev_acv = '0; prev_ac_hs = '0;
        crv_cyc = -1; crv_seen = 0; fwd_cnt = 0; viol = 0; drain = 0;
        got_resp = '0; cr_taken = 1'b0; done = 1'b0; prev_cdv = 1'b0;
        prev_last = 1'b0; prev_data = '0;
        for (int i = 0; i < 4; i++) begin
            cd_cnt[i] = 0;
            dt[i] = v.sel[i] & v.cr[5*i];
        end
        addr = 64'h1000_0000 + 64'(idx) * 64;
        snp  = 4'(idx + 3);
        inp_ac_valid_i = 1'b1; inp_ac_addr_i = addr; inp_ac_snoop_i = snp;
        inp_ac_prot_i = 3'b010; inp_sel_i = v.sel;
        @(negedge clk_i);
        check($sformatf("v%0d_ac_accept", idx), inp_ac_ready_o, 1);
        @(posedge clk_i); #1;
        inp_ac_valid_i = 1'b0; inp_sel_i = '0;
        cyc = 1;
        while (!done && cyc < 80) begin
            for (int i = 0; i < 4; i++) begin
                oup_ac_ready_i[i] = v.sel[i] && (cyc >= int'(v.ac_rdy[i]));
                oup_cr_valid_i[i] = v.sel[i] && !cr_done[i] && (cyc >= int'(v.cr_cyc[i]));
                oup_cr_resp_i[5*i +: 5] = v.cr[5*i +: 5];
                oup_cd_valid_i[i] = cr_done[i] && dt[i] && (cd_cnt[i] < 2);
                oup_cd_data_i[64*i +: 64] = 64'(8'h80 + 8'(16*i) + 8'(cd_cnt[i]));
                oup_cd_last_i[i] = (cd_cnt[i] == 1);
            end
            inp_cr_ready_i = (crv_seen >= v.cr_rdy_dly);
            inp_cd_ready_i = v.cd_toggle ? ((cyc % 2) == 1) : 1'b1;
            @(negedge clk_i);
            for (int i = 0; i < 4; i++) begin
                if (oup_ac_valid_o[i] && !v.sel[i]) viol++;
                if (prev_acv[i] && !prev_ac_hs[i] && !oup_ac_valid_o[i]) viol++;
                if (oup_cr_valid_i[i] && oup_cr_ready_o[i]) begin
                    if (!ac_done[i]) viol++;
                    cr_done[i] = 1'b1;
                end
                prev_acv[i]   = oup_ac_valid_o[i];
                prev_ac_hs[i] = oup_ac_valid_o[i] & oup_ac_ready_i[i];
                if (prev_ac_hs[i]) ac_done[i] = 1'b1;
                if (oup_cd_valid_i[i] && oup_cd_ready_o[i]) begin
                    cd_cnt[i]++;
                    drain++;
                end
            end
            if (|oup_ac_valid_o && (oup_ac_addr_o !== addr || oup_ac_snoop_o !== snp ||
                                    oup_ac_prot_o !== 3'b010)) viol++;
            if (inp_cr_valid_o) begin
                if (crv_seen == 0) begin
                    crv_cyc  = cyc;
                    got_resp = inp_cr_resp_o;
                end else if (inp_cr_resp_o !== got_resp) begin
                    viol++;
                end
                if (cr_taken) viol++;
                crv_seen++;
                if (inp_cr_ready_i) cr_taken = 1'b1;
            end else if (crv_seen > 0 && !cr_taken) begin
                viol++;
            end
            if (prev_cdv && (!inp_cd_valid_o || inp_cd_data_o !== prev_data ||
                             inp_cd_last_o !== prev_last)) viol++;
            if (inp_cd_valid_o && inp_cd_ready_i) begin
                exp_data = 64'(8'h80 + 8'(16*v.exp_src) + 8'(fwd_cnt));
                check($sformatf("v%0d_cd_data%0d", idx, fwd_cnt), inp_cd_data_o, exp_data);
                check($sformatf("v%0d_cd_last%0d", idx, fwd_cnt), inp_cd_last_o, (fwd_cnt == 1));
                fwd_cnt++;
                prev_cdv = 1'b0;
            end else begin
                prev_cdv  = inp_cd_valid_o;
                prev_data = inp_cd_data_o;
                prev_last = inp_cd_last_o;
            end
            if (cr_taken && inp_ac_ready_o) done = 1'b1;
            @(posedge clk_i); #1;
            cyc++;
        end
        idle_inputs();
        check($sformatf("v%0d_done", idx), done, 1);
        check($sformatf("v%0d_resp", idx), got_resp, v.exp_resp);
        check($sformatf("v%0d_crv_cycle", idx), crv_cyc, v.exp_crv);
        check($sformatf("v%0d_fwd_beats", idx), fwd_cnt, v.exp_beats);
        check($sformatf("v%0d_cd_handshakes", idx), drain, v.exp_drain);
        check($sformatf("v%0d_protocol_violations", idx), viol, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk(4'b0101, 20'd0, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2},
                     0, 1'b0, 5'b00000, 3, 0, 0, 0);
        vecs[1] = mk(4'b1111, {5'b01001, 5'b01101, 5'b00000, 5'b00000},
                     {8'd1, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2},
                     0, 1'b0, 5'b01101, 3, 2, 2, 4);
        vecs[2] = mk(4'b0000, 20'd0, {8'd1, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2},
                     0, 1'b0, 5'b00000, 1, 0, 0, 0);
        vecs[3] = mk(4'b0011, {5'b00000, 5'b00000, 5'b00010, 5'b10000},
                     {8'd1, 8'd1, 8'd11, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2},
                     0, 1'b0, 5'b10010, 13, 0, 0, 0);
        vecs[4] = mk(4'b0110, {5'b00000, 5'b01101, 5'b00001, 5'b00000},
                     {8'd1, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2},
                     5, 1'b1, 5'b01001, 3, 1, 2, 4);
        vecs[5] = mk(4'b1000, {5'b00101, 5'b00000, 5'b00000, 5'b00000},
                     {8'd3, 8'd1, 8'd1, 8'd1}, {8'd2, 8'd2, 8'd2, 8'd2},
                     2, 1'b1, 5'b00101, 5, 3, 2, 2);

        idle_inputs();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("reset_outputs", all_out, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("post_reset_ac_ready", inp_ac_ready_o, 1);

        // Reset while port0 still has its AC pending.
        @(posedge clk_i); #1;
        inp_ac_valid_i = 1'b1; inp_ac_addr_i = 64'hDEAD_0000; inp_sel_i = 4'b0001;
        @(negedge clk_i);
        check("mid_ac_accept", inp_ac_ready_o, 1);
        @(posedge clk_i); #1;
        inp_ac_valid_i = 1'b0; inp_sel_i = '0;
        @(negedge clk_i);
        check("mid_ac_valid", oup_ac_valid_o, 4'b0001);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check("mid_reset_outputs", all_out, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_reset_release", {inp_ac_ready_o, oup_ac_valid_o}, 5'b10000);
        @(posedge clk_i); #1;

        for (int k = 0; k < 6; k++) begin
            run_vec(k, vecs[k]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
